// File: rtl/mips_dbg_pkg.sv
// Shared debug encodings for the MIPS_DLX execution controller and the host-side debug unit.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_BREAK = 3'd3,
        ST_DONE  = 3'd4
    } exec_state_t;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_HALT  = 2'b11;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_BP         = 2'b01;
    localparam logic [1:0] CAUSE_HALT_INSTR = 2'b10;
    localparam logic [1:0] CAUSE_HOST       = 2'b11;

endpackage

// File: rtl/mips_exec_controller.sv
// Run/step/halt sequencer: sole driver of the MIPS_DLX global enable, with breakpoint
// gating, halt-instruction retirement stop and a saturating enabled-cycle counter.
module mips_exec_controller
    import mips_dbg_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int STEP_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_code,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              halt_retire,
    output logic              cpu_enable,
    output logic [2:0]        state_o,
    output logic [1:0]        stop_cause,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    exec_state_t       state_r;
    logic [1:0]        stop_cause_r;
    logic [CNT_W-1:0]  cycle_cnt_r;
    logic [STEP_W-1:0] step_left_r;
    logic              bp_skip_r;

    logic              running_s;
    logic              bp_hit_s;
    logic              accept_s;
    logic              resumable_s;
    logic              expire_s;
    logic [STEP_W-1:0] step_load_s;

    // Breakpoint gating is combinational so the breakpoint instruction is never fetched.
    always_comb begin
        running_s   = (state_r == ST_RUN) || (state_r == ST_STEP);
        bp_hit_s    = bp_en && (fetch_pc == bp_addr) && !bp_skip_r;
        cpu_enable  = running_s && !bp_hit_s;
        cmd_ready   = (state_r != ST_DONE) || (cmd_code == CMD_CLEAR);
        accept_s    = cmd_valid && cmd_ready;
        resumable_s = (state_r == ST_IDLE) || (state_r == ST_BREAK);
        expire_s    = cpu_enable && (state_r == ST_STEP) && (step_left_r == STEP_ONE);
        if (cmd_arg == {STEP_W{1'b0}}) begin
            step_load_s = STEP_ONE;
        end else begin
            step_load_s = cmd_arg;
        end
    end

    // Sequencer state, stop cause, step budget, breakpoint skip and cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            stop_cause_r <= CAUSE_NONE;
            cycle_cnt_r  <= {CNT_W{1'b0}};
            step_left_r  <= {STEP_W{1'b0}};
            bp_skip_r    <= 1'b0;
        end else begin
            if (cpu_enable && (cycle_cnt_r != CNT_MAX)) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end
            if (cpu_enable) begin
                bp_skip_r <= 1'b0;
            end
            if (cpu_enable && (state_r == ST_STEP)) begin
                step_left_r <= step_left_r - STEP_ONE;
            end

            // Event priority: CLEAR > halt retire > breakpoint > host HALT > step expiry.
            if (accept_s && (cmd_code == CMD_CLEAR)) begin
                state_r      <= ST_IDLE;
                stop_cause_r <= CAUSE_NONE;
                cycle_cnt_r  <= {CNT_W{1'b0}};
                bp_skip_r    <= 1'b0;
            end else if (running_s && halt_retire) begin
                state_r      <= ST_DONE;
                stop_cause_r <= CAUSE_HALT_INSTR;
            end else if (running_s && bp_hit_s) begin
                state_r      <= ST_BREAK;
                stop_cause_r <= CAUSE_BP;
            end else if (running_s && accept_s && (cmd_code == CMD_HALT)) begin
                state_r      <= ST_IDLE;
                stop_cause_r <= CAUSE_HOST;
            end else if (expire_s) begin
                state_r <= ST_IDLE;
            end else if (resumable_s && accept_s && (cmd_code == CMD_RUN)) begin
                state_r      <= ST_RUN;
                stop_cause_r <= CAUSE_NONE;
                bp_skip_r    <= (state_r == ST_BREAK);
            end else if (resumable_s && accept_s && (cmd_code == CMD_STEP)) begin
                state_r      <= ST_STEP;
                stop_cause_r <= CAUSE_NONE;
                step_left_r  <= step_load_s;
                bp_skip_r    <= (state_r == ST_BREAK);
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign state_o    = state_r;
    assign stop_cause = stop_cause_r;
    assign cycle_cnt  = cycle_cnt_r;

endmodule

// File: tb/tb_mips_exec_controller.sv
// Bench for mips_exec_controller: directed scenarios plus randomized traffic against a cycle model.
module tb_mips_exec_controller;

    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_BREAK = 3, S_DONE = 4;
    localparam logic [1:0] C_CLEAR = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_code = 2'b00;
    logic [7:0]  cmd_arg = 8'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] fetch_pc = 32'd0;
    logic        halt_retire = 1'b0;
    logic        cmd_ready, cpu_enable, cmd_ready_4, cpu_enable_4;
    logic [2:0]  state_o, state_o_4;
    logic [1:0]  stop_cause, stop_cause_4;
    logic [31:0] cycle_cnt;
    logic [3:0]  cycle_cnt_4;

    int checks = 0;
    int errors = 0;
    bit auto_pc = 1'b0;

    // Reference model: spec-level run mode, remaining steps, skip flag, cause, unbounded count.
    int     m_state;
    int     m_steps;
    bit     m_skip;
    int     m_cause;
    longint m_cnt;

    mips_exec_controller #(.PC_W(32), .STEP_W(8), .CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr),
        .fetch_pc(fetch_pc), .halt_retire(halt_retire), .cpu_enable(cpu_enable),
        .state_o(state_o), .stop_cause(stop_cause), .cycle_cnt(cycle_cnt)
    );

    mips_exec_controller #(.PC_W(32), .STEP_W(8), .CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_4),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr),
        .fetch_pc(fetch_pc), .halt_retire(halt_retire), .cpu_enable(cpu_enable_4),
        .state_o(state_o_4), .stop_cause(stop_cause_4), .cycle_cnt(cycle_cnt_4)
    );

    always #5 clock = ~clock;

    task automatic m_reset();
        m_state = S_IDLE; m_steps = 0; m_skip = 1'b0; m_cause = 0; m_cnt = 0;
    endtask

    function automatic bit m_running();
        return (m_state == S_RUN) || (m_state == S_STEP);
    endfunction

    function automatic bit m_enable();
        return m_running() && !(bp_en && fetch_pc == bp_addr && !m_skip);
    endfunction

    function automatic bit m_ready();
        return (m_state != S_DONE) || (cmd_code == C_CLEAR);
    endfunction

    // One clock: predict the outcome from the inputs in front of the edge, then advance.
    task automatic tick();
        bit en, acc, hit, run, last;
        run  = m_running();
        hit  = bp_en && fetch_pc == bp_addr && !m_skip;
        en   = run && !hit;
        acc  = cmd_valid && m_ready();
        last = en && m_state == S_STEP && m_steps == 1;
        @(posedge clock);
        if (en) begin
            m_cnt++;
            m_skip = 1'b0;
            if (m_state == S_STEP) m_steps--;
        end
        if (acc && cmd_code == C_CLEAR) begin
            m_state = S_IDLE; m_cause = 0; m_cnt = 0; m_skip = 1'b0;
        end else if (run && halt_retire) begin
            m_state = S_DONE; m_cause = 2;
        end else if (run && hit) begin
            m_state = S_BREAK; m_cause = 1;
        end else if (run && acc && cmd_code == C_HALT) begin
            m_state = S_IDLE; m_cause = 3;
        end else if (last) begin
            m_state = S_IDLE;
        end else if (acc && (m_state == S_IDLE || m_state == S_BREAK) &&
                     (cmd_code == C_RUN || cmd_code == C_STEP)) begin
            m_skip  = (m_state == S_BREAK);
            m_state = (cmd_code == C_RUN) ? S_RUN : S_STEP;
            m_cause = 0;
            if (cmd_code == C_STEP) m_steps = (cmd_arg == 8'd0) ? 1 : int'(cmd_arg);
        end
        #1;
        if (auto_pc && en) fetch_pc = fetch_pc + 32'd4;
    endtask

    task automatic send(input logic [1:0] code, input logic [7:0] arg);
        cmd_valid = 1'b1; cmd_code = code; cmd_arg = arg;
        tick();
        cmd_valid = 1'b0; cmd_code = C_CLEAR; cmd_arg = 8'd0;
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        #12;
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", cpu_enable); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (stop_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", stop_cause); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cycle_cnt); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_halt_retire();
        int n = 0;
        send(C_RUN, 8'd0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 20) halt_retire = 1'b1;
            #1;
            if (cpu_enable) n++;
            tick();
            halt_retire = 1'b0;
        end
        #1;
        checks++; if (n != 20) begin errors++; $display("FAIL halt_enabled_cycles got %0d want 20", n); end
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL halt_enable_after got %b want 0", cpu_enable); end
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL halt_state got %0d want 4", state_o); end
        checks++; if (stop_cause !== 2'd2) begin errors++; $display("FAIL halt_cause got %0d want 2", stop_cause); end
        checks++; if (cycle_cnt !== 32'd20) begin errors++; $display("FAIL halt_cnt got %0d want 20", cycle_cnt); end
        cmd_valid = 1'b1; cmd_code = C_RUN; #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL done_ready_run got %b want 0", cmd_ready); end
        tick();
        cmd_valid = 1'b0; #1;
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL done_run_ignored got %0d want 4", state_o); end
        send(C_CLEAR, 8'd0);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL clear_state got %0d want 0", state_o); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL clear_cnt got %0d want 0", cycle_cnt); end
        checks++; if (stop_cause !== 2'd0) begin errors++; $display("FAIL clear_cause got %0d want 0", stop_cause); end
    endtask

    task automatic test_breakpoint();
        int n = 0;
        bit seen_gate = 1'b0;
        fetch_pc = 32'd0; bp_addr = 32'h40; bp_en = 1'b1; auto_pc = 1'b1;
        send(C_RUN, 8'd0);
        for (int i = 0; i < 40; i++) begin
            if (state_o !== 3'd1) break;
            if (cpu_enable) n++;
            if (fetch_pc == 32'h40 && cpu_enable === 1'b0) seen_gate = 1'b1;
            tick();
            #1;
        end
        checks++; if (seen_gate !== 1'b1) begin errors++; $display("FAIL bp_gate got %b want 1", seen_gate); end
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL bp_state got %0d want 3", state_o); end
        checks++; if (stop_cause !== 2'd1) begin errors++; $display("FAIL bp_cause got %0d want 1", stop_cause); end
        checks++; if (cycle_cnt !== 32'd16) begin errors++; $display("FAIL bp_cnt got %0d want 16", cycle_cnt); end
        checks++; if (n != 16) begin errors++; $display("FAIL bp_enabled_cycles got %0d want 16", n); end
        send(C_RUN, 8'd0);
        checks++; if (cpu_enable !== 1'b1 || fetch_pc !== 32'h40) begin errors++; $display("FAIL bp_resume got en=%b pc=%h want en=1 pc=40", cpu_enable, fetch_pc); end
        tick(); #1;
        checks++; if (cpu_enable !== 1'b1 || fetch_pc !== 32'h44 || state_o !== 3'd1) begin errors++; $display("FAIL bp_continue got en=%b pc=%h st=%0d want 1/44/1", cpu_enable, fetch_pc, state_o); end
        send(C_HALT, 8'd0);
        bp_en = 1'b0;
    endtask

    task automatic test_step();
        int n;
        logic [7:0] args [2] = '{8'd3, 8'd0};
        int want [2] = '{3, 1};
        send(C_CLEAR, 8'd0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            send(C_STEP, args[k]);
            for (int i = 0; i < 10; i++) begin
                if (state_o !== 3'd2) break;
                if (cpu_enable) n++;
                tick(); #1;
            end
            checks++; if (n != want[k]) begin errors++; $display("FAIL step_count arg=%0d got %0d want %0d", args[k], n, want[k]); end
            checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL step_end_state arg=%0d got %0d want 0", args[k], state_o); end
        end
        bp_en = 1'b1; bp_addr = fetch_pc;
        send(C_RUN, 8'd0);
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL step_bp_gate got %b want 0", cpu_enable); end
        tick(); #1;
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL step_bp_break got %0d want 3", state_o); end
        send(C_STEP, 8'd1);
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL step_past_bp got %b want 1", cpu_enable); end
        tick(); #1;
        checks++; if (state_o !== 3'd0 || fetch_pc !== bp_addr + 32'd4) begin errors++; $display("FAIL step_past_bp_end got st=%0d pc=%h want 0/%h", state_o, fetch_pc, bp_addr + 32'd4); end
        bp_en = 1'b0;
    endtask

    task automatic test_host_halt();
        int n = 0;
        send(C_CLEAR, 8'd0);
        send(C_RUN, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) begin cmd_valid = 1'b1; cmd_code = C_HALT; end
            #1;
            if (cpu_enable) n++;
            tick();
        end
        cmd_valid = 1'b0; cmd_code = C_CLEAR; #1;
        checks++; if (n != 7) begin errors++; $display("FAIL hhalt_enabled got %0d want 7", n); end
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL hhalt_enable_after got %b want 0", cpu_enable); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL hhalt_state got %0d want 0", state_o); end
        checks++; if (stop_cause !== 2'd3) begin errors++; $display("FAIL hhalt_cause got %0d want 3", stop_cause); end
        checks++; if (cycle_cnt !== 32'd7) begin errors++; $display("FAIL hhalt_cnt got %0d want 7", cycle_cnt); end
    endtask

    task automatic test_saturation();
        send(C_CLEAR, 8'd0);
        send(C_RUN, 8'd0);
        for (int i = 0; i < 20; i++) tick();
        #1;
        checks++; if (cycle_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide got %0d want 20", cycle_cnt); end
        checks++; if (cycle_cnt_4 !== 4'd15) begin errors++; $display("FAIL sat_narrow got %0d want 15", cycle_cnt_4); end
        send(C_HALT, 8'd0);
    endtask

    task automatic test_reset_midrun();
        send(C_RUN, 8'd0);
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b0 || cpu_enable_4 !== 1'b0) begin errors++; $display("FAIL rst_mid_enable got %b/%b want 0", cpu_enable, cpu_enable_4); end
        checks++; if (state_o !== 3'd0 || cmd_ready !== 1'b1 || stop_cause !== 2'd0) begin errors++; $display("FAIL rst_mid_outputs got st=%0d rdy=%b cause=%0d", state_o, cmd_ready, stop_cause); end
        checks++; if (cycle_cnt !== 32'd0 || cycle_cnt_4 !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d/%0d want 0", cycle_cnt, cycle_cnt_4); end
        m_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] exp_cnt;
        logic [3:0]  exp_cnt4;
        auto_pc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cmd_valid   = ($urandom_range(0, 2) == 0);
            cmd_code    = 2'($urandom_range(0, 3));
            cmd_arg     = 8'($urandom_range(0, 4));
            bp_en       = ($urandom_range(0, 1) == 1);
            bp_addr     = 32'($urandom_range(0, 3)) * 32'd4;
            fetch_pc    = 32'($urandom_range(0, 3)) * 32'd4;
            halt_retire = m_running() && ($urandom_range(0, 15) == 0);
            #1;
            exp_cnt  = m_cnt[31:0];
            exp_cnt4 = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
            checks++; if (cpu_enable !== m_enable()) begin errors++; $display("FAIL rnd_enable cyc=%0d got %b want %b", i, cpu_enable, m_enable()); end
            checks++; if (cmd_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", i, cmd_ready, m_ready()); end
            checks++; if (state_o !== 3'(m_state)) begin errors++; $display("FAIL rnd_state cyc=%0d got %0d want %0d", i, state_o, m_state); end
            checks++; if (stop_cause !== 2'(m_cause)) begin errors++; $display("FAIL rnd_cause cyc=%0d got %0d want %0d", i, stop_cause, m_cause); end
            checks++; if (cycle_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt cyc=%0d got %0d want %0d", i, cycle_cnt, exp_cnt); end
            checks++; if (cycle_cnt_4 !== exp_cnt4) begin errors++; $display("FAIL rnd_cnt4 cyc=%0d got %0d want %0d", i, cycle_cnt_4, exp_cnt4); end
            tick();
        end
        cmd_valid = 1'b0; halt_retire = 1'b0; bp_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_halt_retire();
        test_breakpoint();
        test_step();
        test_host_halt();
        test_saturation();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
